header_fetch_master: RTL and testbench

Avalon-MM bus master that fetches a block of 32-bit words (the 80-byte block header, 20 words) from SDRAM and streams them to the hashing core. On request it writes one result word (found nonce/status) back to SDRAM. It is the initiator counterpart of the CSR slave: the slave's CSRs supply the base addresses and start strobe, and this block drives the `master_*` port of the same Avalon interface.

---
 rtl/header_fetch_master.sv | 134 +++++++++++++
 tb/tb_header_fetch_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/header_fetch_master.sv
// header_fetch_master: Avalon-MM master that fetches a block of words one read at a time
// and optionally writes a single result word back once the fetch completes.
module header_fetch_master #(
    parameter int MASTER_ADDRESSWIDTH = 26,
    parameter int DATAWIDTH           = 32,
    parameter int MAXWORDS            = 20,
    parameter int CNTWIDTH            = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [MASTER_ADDRESSWIDTH-1:0] rd_base,
    input  logic [CNTWIDTH-1:0]            rd_count,
    input  logic                           wb_en,
    input  logic [MASTER_ADDRESSWIDTH-1:0] wb_addr,
    input  logic [DATAWIDTH-1:0]           wb_data,
    output logic                           busy,
    output logic                           done,
    output logic [DATAWIDTH-1:0]           word_out,
    output logic [CNTWIDTH-1:0]            word_idx,
    output logic                           word_valid,
    output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
    output logic                           master_read,
    output logic                           master_write,
    output logic [DATAWIDTH-1:0]           master_writedata,
    input  logic [DATAWIDTH-1:0]           master_readdata,
    input  logic                           master_readdatavalid,
    input  logic                           master_waitrequest
);
    localparam logic [CNTWIDTH-1:0] MAXCNT = CNTWIDTH'(MAXWORDS);

    typedef enum logic [2:0] {IDLE, READ_REQ, READ_WAIT, WRITE, DONE} state_t;

    state_t                         r_state;
    logic [CNTWIDTH-1:0]            r_count;
    logic [CNTWIDTH-1:0]            r_idx;
    logic [MASTER_ADDRESSWIDTH-1:0] r_addr;
    logic                           r_wb_en;
    logic [MASTER_ADDRESSWIDTH-1:0] r_wb_addr;
    logic [DATAWIDTH-1:0]           r_wb_data;
    logic [CNTWIDTH-1:0]            w_count;
    logic [CNTWIDTH-1:0]            w_idx_next;
    logic [MASTER_ADDRESSWIDTH-1:0] w_base;
    logic [MASTER_ADDRESSWIDTH-1:0] w_addr_next;

    always_comb begin
        w_count     = (rd_count > MAXCNT) ? MAXCNT : rd_count;
        w_idx_next  = r_idx + CNTWIDTH'(1);
        w_base      = rd_base & ~MASTER_ADDRESSWIDTH'(3);
        w_addr_next = r_addr + MASTER_ADDRESSWIDTH'(4);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_count          <= '0;
            r_idx            <= '0;
            r_addr           <= '0;
            r_wb_en          <= 1'b0;
            r_wb_addr        <= '0;
            r_wb_data        <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            word_out         <= '0;
            word_idx         <= '0;
            word_valid       <= 1'b0;
            master_address   <= '0;
            master_read      <= 1'b0;
            master_write     <= 1'b0;
            master_writedata <= '0;
        end else begin
            word_valid <= 1'b0;
            done       <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_count   <= w_count;
                    r_idx     <= '0;
                    r_addr    <= w_base;
                    r_wb_en   <= wb_en;
                    r_wb_addr <= wb_addr;
                    r_wb_data <= wb_data;
                    busy      <= 1'b1;
                    if (w_count != '0) begin
                        r_state        <= READ_REQ;
                        master_read    <= 1'b1;
                        master_address <= w_base;
                    end else if (wb_en) begin
                        r_state          <= WRITE;
                        master_write     <= 1'b1;
                        master_address   <= wb_addr;
                        master_writedata <= wb_data;
                    end else begin
                        r_state <= DONE;
                    end
                end
                READ_REQ: if (!master_waitrequest) begin
                    master_read <= 1'b0;
                    r_state     <= READ_WAIT;
                end
                READ_WAIT: if (master_readdatavalid) begin
                    word_valid <= 1'b1;
                    word_out   <= master_readdata;
                    word_idx   <= r_idx;
                    r_idx      <= w_idx_next;
                    r_addr     <= w_addr_next;
                    if (w_idx_next != r_count) begin
                        r_state        <= READ_REQ;
                        master_read    <= 1'b1;
                        master_address <= w_addr_next;
                    end else if (r_wb_en) begin
                        r_state          <= WRITE;
                        master_write     <= 1'b1;
                        master_address   <= r_wb_addr;
                        master_writedata <= r_wb_data;
                    end else begin
                        r_state <= DONE;
                    end
                end
                WRITE: if (!master_waitrequest) begin
                    master_write <= 1'b0;
                    done         <= 1'b1;
                    r_state      <= DONE;
                end
                // A write completion pulses done on entry; other paths pulse it on leaving DONE.
                DONE: begin
                    done    <= ~done;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_header_fetch_master.sv
// tb_header_fetch_master: directed bench with an Avalon slave responder and bus monitor.
module tb_header_fetch_master;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [25:0] rd_base = '0;
    logic [4:0]  rd_count = '0;
    logic        wb_en = 1'b0;
    logic [25:0] wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        busy, done, word_valid, master_read, master_write;
    logic [31:0] word_out, master_writedata;
    logic [4:0]  word_idx;
    logic [25:0] master_address;
    logic [31:0] rdata = '0;
    logic        rdv = 1'b0;
    logic        manual_rdv = 1'b0;
    logic        waitreq = 1'b0;

    int n_err = 0, n_checks = 0;
    int cyc = 0, n_reads = 0, n_valid = 0, n_writes = 0, n_done = 0;
    int b_reads = 0, b_valid = 0, b_writes = 0, b_done = 0;
    int valid_cyc = 0, done_cyc = 0, wr_start_cyc = 0, wr_acc_cyc = 0;
    int stall_n = 0;
    logic        resp_en = 1'b1;
    logic [25:0] exp_base = '0, last_rd_addr = '0, wr_addr = '0;
    logic [31:0] data_base = '0, wr_data = '0;

    header_fetch_master dut (
        .clk(clk), .reset(reset), .start(start), .rd_base(rd_base), .rd_count(rd_count),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy), .done(done),
        .word_out(word_out), .word_idx(word_idx), .word_valid(word_valid),
        .master_address(master_address), .master_read(master_read), .master_write(master_write),
        .master_writedata(master_writedata), .master_readdata(rdata),
        .master_readdatavalid(rdv | manual_rdv), .master_waitrequest(waitreq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Responder and monitor share one process so both see the same waitrequest.
    initial begin
        int          hold = 0;
        logic        pend = 1'b0, prev_stall = 1'b0, prev_write = 1'b0;
        logic [31:0] pend_data = '0;
        logic [59:0] prev_vec = '0;
        logic [25:0] ea;
        forever begin
            @(negedge clk);
            cyc++;
            rdv   = pend;
            rdata = pend_data;
            if (master_read || master_write) begin
                waitreq = (hold < stall_n);
                hold++;
            end else begin
                waitreq = 1'b0;
                hold = 0;
            end
            pend = resp_en && master_read && !waitreq;
            if (pend) pend_data = data_base + 32'(n_reads - b_reads);
            if (master_read || master_write) chk("rd_wr_excl", 64'(master_read & master_write), 64'd0);
            if (prev_stall) chk("stall_hold", 64'({master_read, master_write, master_address, master_writedata}), 64'(prev_vec));
            if (master_read && !waitreq) begin
                ea = exp_base + 26'((n_reads - b_reads) * 4);
                chk("rd_addr", 64'(master_address), 64'(ea));
                last_rd_addr = master_address;
                n_reads++;
            end
            if (master_write && !prev_write) wr_start_cyc = cyc;
            if (master_write && !waitreq) begin
                wr_addr = master_address;
                wr_data = master_writedata;
                wr_acc_cyc = cyc;
                n_writes++;
            end
            if (word_valid) begin
                chk("word_idx", 64'(word_idx), 64'(n_valid - b_valid));
                chk("word_out", 64'(word_out), 64'(data_base + 32'(n_valid - b_valid)));
                valid_cyc = cyc;
                n_valid++;
            end
            if (done) begin
                done_cyc = cyc;
                n_done++;
            end
            prev_stall = (master_read || master_write) && waitreq;
            prev_vec   = {master_read, master_write, master_address, master_writedata};
            prev_write = master_write;
        end
    end

    task automatic snap(input logic [25:0] eb, input logic [31:0] db, input int st);
        b_reads = n_reads;
        b_valid = n_valid;
        b_writes = n_writes;
        b_done = n_done;
        exp_base = eb;
        data_base = db;
        stall_n = st;
    endtask

    task automatic go(input logic [25:0] base, input logic [4:0] cnt, input logic we,
                      input logic [25:0] wa, input logic [31:0] wd);
        rd_base = base;
        rd_count = cnt;
        wb_en = we;
        wb_addr = wa;
        wb_data = wd;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        logic ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            tick();
            ok = (n_done > b_done) && !busy;
        end
        chk("idle_timeout", 64'(ok), 64'd1);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(word_valid), 64'd0);
        chk("rst_rdwr", 64'({master_read, master_write}), 64'd0);
        chk("rst_addr", 64'(master_address), 64'd0);
        chk("rst_wdata", 64'(master_writedata), 64'd0);
        chk("rst_word", 64'({word_out, word_idx}), 64'd0);
        reset = 1'b0;
        tick();

        snap(26'h0800000, 32'h100, 0);
        go(26'h0800000, 5'd20, 1'b0, '0, '0);
        chk("basic_busy", 64'(busy), 64'd1);
        chk("basic_read", 64'(master_read), 64'd1);
        chk("basic_addr0", 64'(master_address), 64'h0800000);
        wait_idle(200);
        chk("basic_reads", 64'(n_reads - b_reads), 64'd20);
        chk("basic_valid", 64'(n_valid - b_valid), 64'd20);
        chk("basic_writes", 64'(n_writes - b_writes), 64'd0);
        chk("basic_done", 64'(n_done - b_done), 64'd1);
        chk("basic_last_addr", 64'(last_rd_addr), 64'h080004C);
        chk("basic_done_lat", 64'(done_cyc - valid_cyc), 64'd1);

        snap(26'h0000200, 32'h200, 3);
        go(26'h0000200, 5'd4, 1'b1, 26'h0000100, 32'hDEADF00B);
        wait_idle(200);
        chk("stall_reads", 64'(n_reads - b_reads), 64'd4);
        chk("stall_valid", 64'(n_valid - b_valid), 64'd4);
        chk("stall_writes", 64'(n_writes - b_writes), 64'd1);
        chk("stall_wr_addr", 64'(wr_addr), 64'h100);
        chk("stall_wr_data", 64'(wr_data), 64'hDEADF00B);
        chk("stall_wr_start", 64'(wr_start_cyc - valid_cyc), 64'd0);
        chk("stall_done_lat", 64'(done_cyc - wr_acc_cyc), 64'd1);
        chk("stall_done", 64'(n_done - b_done), 64'd1);

        snap('0, '0, 0);
        go('0, 5'd0, 1'b0, '0, '0);
        chk("zero_busy", 64'(busy), 64'd1);
        chk("zero_done_t1", 64'(done), 64'd0);
        tick();
        chk("zero_done_t2", 64'(done), 64'd1);
        tick();
        tick();
        chk("zero_bus", 64'((n_reads - b_reads) + (n_writes - b_writes)), 64'd0);
        chk("zero_done_cnt", 64'(n_done - b_done), 64'd1);

        snap(26'h0001000, 32'h300, 0);
        go(26'h0001000, 5'd31, 1'b0, '0, '0);
        wait_idle(200);
        chk("clamp_reads", 64'(n_reads - b_reads), 64'd20);
        chk("clamp_valid", 64'(n_valid - b_valid), 64'd20);

        snap(26'h3FFFFFC, 32'h400, 0);
        go(26'h3FFFFFF, 5'd2, 1'b0, '0, '0);
        wait_idle(100);
        chk("wrap_reads", 64'(n_reads - b_reads), 64'd2);
        chk("wrap_addr1", 64'(last_rd_addr), 64'd0);

        snap(26'h0002000, 32'h500, 0);
        go(26'h0002000, 5'd3, 1'b0, '0, '0);
        tick();
        go(26'h0003000, 5'd7, 1'b1, 26'h0000040, 32'h12345678);
        wait_idle(100);
        repeat (10) tick();
        chk("rebusy_reads", 64'(n_reads - b_reads), 64'd3);
        chk("rebusy_valid", 64'(n_valid - b_valid), 64'd3);
        chk("rebusy_writes", 64'(n_writes - b_writes), 64'd0);
        chk("rebusy_done", 64'(n_done - b_done), 64'd1);

        resp_en = 1'b0;
        snap(26'h0004000, 32'h600, 0);
        go(26'h0004000, 5'd5, 1'b0, '0, '0);
        tick();
        chk("mid_in_wait", 64'({busy, master_read}), 64'b10);
        reset = 1'b1;
        tick();
        chk("mid_rst_ctl", 64'({busy, done, word_valid, master_read, master_write}), 64'd0);
        chk("mid_rst_addr", 64'(master_address), 64'd0);
        chk("mid_rst_word", 64'({word_out, word_idx}), 64'd0);
        reset = 1'b0;
        manual_rdv = 1'b1;
        tick();
        manual_rdv = 1'b0;
        tick();
        tick();
        chk("mid_late_valid", 64'(n_valid - b_valid), 64'd0);
        chk("mid_idle", 64'(busy), 64'd0);
        resp_en = 1'b1;

        snap(26'h0005000, 32'h700, 0);
        reset = 1'b1;
        go(26'h0005000, 5'd2, 1'b0, '0, '0);
        chk("rst_start_ctl", 64'({busy, master_read}), 64'd0);
        reset = 1'b0;
        tick();
        tick();
        chk("rst_start_idle", 64'({busy, master_read}), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
